// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner
//  Description : Player-input front end for the ping-pong board. Every raw
//                BTN/SW line is synchronised (2 flops) and debounced by an
//                independent per-channel counter. Registered outputs give
//                clean levels and one-cycle press/rise/release strobes. Two
//                hold trackers count game ticks while the paddle switches
//                (SW[0] right, SW[15] left) stay on.
//  Ports       : clk, resetn (async, active-low)
//                BTN[4:0], SW[15:0]  raw asynchronous inputs
//                tick                one-cycle game-step strobe
//                btn_level/press/release, sw_level/rise  debounced outputs
//                paddle_hold_r/l     paddle switch held >= HOLD_TICKS ticks
//  Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner #(
    parameter int DEB_CYCLES = 1000000,
    parameter int HOLD_TICKS = 21
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  BTN,
    input  logic [15:0] SW,
    input  logic        tick,
    output logic [4:0]  btn_level,
    output logic [4:0]  btn_press,
    output logic [4:0]  btn_release,
    output logic [15:0] sw_level,
    output logic [15:0] sw_rise,
    output logic        paddle_hold_r,
    output logic        paddle_hold_l
);

    localparam int c_N_BTN = 5;
    localparam int c_N_CH  = 21;
    localparam int c_CH_R  = c_N_BTN + 0;    // channel index of SW[0]
    localparam int c_CH_L  = c_N_BTN + 15;   // channel index of SW[15]
    localparam int c_DCW   = $clog2(DEB_CYCLES + 1);
    localparam int c_HCW   = $clog2(HOLD_TICKS + 1);

    localparam logic [c_DCW-1:0] c_DC_LAST  = c_DCW'(DEB_CYCLES - 1);
    localparam logic [c_HCW-1:0] c_HOLD_MAX = c_HCW'(HOLD_TICKS);

    // Channels 0..4 are the buttons, 5..20 the switches.
    logic [c_N_CH-1:0]  w_raw;
    logic [c_N_CH-1:0]  w_level;
    logic [c_N_CH-1:0]  w_rise;
    logic [c_N_BTN-1:0] w_fall;
    logic [1:0]         w_pad_next;   // next-cycle debounced level of SW[0]/SW[15]
    logic [1:0]         w_hold;

    assign w_raw = {SW, BTN};

    genvar gi;
    generate
        for (gi = 0; gi < c_N_CH; gi++) begin : g_ch
            logic [1:0]       r_sync;
            logic [c_DCW-1:0] r_dc;
            logic             r_level;
            logic             r_rise;
            logic             w_diff;
            logic             w_flip;

            assign w_diff = r_sync[1] ^ r_level;
            // The level flips on the same edge the strobe registers, so the
            // strobe is high exactly in the first cycle the new level shows.
            assign w_flip = w_diff && (r_dc == c_DC_LAST);

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_sync  <= 2'b00;
                    r_dc    <= '0;
                    r_level <= 1'b0;
                    r_rise  <= 1'b0;
                end else begin
                    r_sync <= {r_sync[0], w_raw[gi]};
                    if (!w_diff || w_flip) begin
                        r_dc <= '0;
                    end else begin
                        r_dc <= r_dc + 1'b1;
                    end
                    if (w_flip) begin
                        r_level <= ~r_level;
                    end
                    r_rise <= w_flip & ~r_level;
                end
            end

            assign w_level[gi] = r_level;
            assign w_rise[gi]  = r_rise;

            if (gi < c_N_BTN) begin : g_rel
                logic r_fall;
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        r_fall <= 1'b0;
                    end else begin
                        r_fall <= w_flip & r_level;
                    end
                end
                assign w_fall[gi] = r_fall;
            end

            // Hold trackers look at the level being loaded this edge, so a
            // tick coincident with the debounced rise is counted and a fall
            // clears the counter in the same cycle.
            if (gi == c_CH_R) begin : g_pad_r
                assign w_pad_next[0] = r_level ^ w_flip;
            end else if (gi == c_CH_L) begin : g_pad_l
                assign w_pad_next[1] = r_level ^ w_flip;
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_hold
            logic [c_HCW-1:0] r_hc;
            logic             r_hold;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_hc   <= '0;
                    r_hold <= 1'b0;
                end else begin
                    if (!w_pad_next[gi]) begin
                        r_hc <= '0;
                    end else if (tick && (r_hc != c_HOLD_MAX)) begin
                        r_hc <= r_hc + 1'b1;
                    end
                    r_hold <= (r_hc == c_HOLD_MAX);
                end
            end

            assign w_hold[gi] = r_hold;
        end
    endgenerate

    assign btn_level     = w_level[c_N_BTN-1:0];
    assign sw_level      = w_level[c_N_CH-1:c_N_BTN];
    assign btn_press     = w_rise[c_N_BTN-1:0];
    assign sw_rise       = w_rise[c_N_CH-1:c_N_BTN];
    assign btn_release   = w_fall;
    assign paddle_hold_r = w_hold[0];
    assign paddle_hold_l = w_hold[1];

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_conditioner
//  Description : Directed self-checking bench for input_conditioner with
//                DEB_CYCLES=4, HOLD_TICKS=3. Inputs change 1 ns after a
//                rising edge; outputs are sampled at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    logic        clk;
    logic        resetn;
    logic [4:0]  BTN;
    logic [15:0] SW;
    logic        tick;
    logic [4:0]  btn_level;
    logic [4:0]  btn_press;
    logic [4:0]  btn_release;
    logic [15:0] sw_level;
    logic [15:0] sw_rise;
    logic        paddle_hold_r;
    logic        paddle_hold_l;

    int n_checks = 0;
    int n_fail   = 0;

    input_conditioner #(
        .DEB_CYCLES (4),
        .HOLD_TICKS (3)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .BTN           (BTN),
        .SW            (SW),
        .tick          (tick),
        .btn_level     (btn_level),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .sw_level      (sw_level),
        .sw_rise       (sw_rise),
        .paddle_hold_r (paddle_hold_r),
        .paddle_hold_l (paddle_hold_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    bit pat [6];

    initial begin
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // ---------------- reset with all inputs high ----------------
        resetn = 1'b0;
        BTN    = 5'h1F;
        SW     = 16'hFFFF;
        tick   = 1'b0;
        steps(10);
        chk("rst_btn_level", 32'(btn_level), 32'h0);
        chk("rst_sw_level", 32'(sw_level), 32'h0);
        chk("rst_holds", 32'({paddle_hold_l, paddle_hold_r}), 32'h0);
        resetn = 1'b1;
        steps(5);
        chk("post_rst_5_level", 32'(btn_level), 32'h0);
        chk("post_rst_5_press", 32'(btn_press), 32'h0);
        step();
        chk("post_rst_6_btn_level", 32'(btn_level), 32'h1F);
        chk("post_rst_6_sw_level", 32'(sw_level), 32'hFFFF);
        chk("post_rst_6_btn_press", 32'(btn_press), 32'h1F);
        chk("post_rst_6_sw_rise", 32'(sw_rise), 32'hFFFF);
        step();
        chk("post_rst_7_btn_press", 32'(btn_press), 32'h0);
        chk("post_rst_7_sw_rise", 32'(sw_rise), 32'h0);

        // all inputs back to 0
        BTN = 5'h00;
        SW  = 16'h0000;
        steps(6);
        chk("all_low_release", 32'(btn_release), 32'h1F);
        chk("all_low_level", 32'(sw_level), 32'h0);
        steps(2);

        // ---------------- clean press of BTN[2] ----------------
        BTN[2] = 1'b1;
        steps(5);
        chk("press_early_level", 32'(btn_level), 32'h0);
        chk("press_early_strobe", 32'(btn_press), 32'h0);
        step();
        chk("press_level", 32'(btn_level), 32'h04);
        chk("press_strobe", 32'(btn_press), 32'h04);
        step();
        chk("press_strobe_width", 32'(btn_press), 32'h0);
        steps(13);
        BTN[2] = 1'b0;
        steps(5);
        chk("release_early", 32'(btn_release), 32'h0);
        chk("release_early_level", 32'(btn_level), 32'h04);
        step();
        chk("release_strobe", 32'(btn_release), 32'h04);
        chk("release_level", 32'(btn_level), 32'h0);
        step();
        chk("release_strobe_width", 32'(btn_release), 32'h0);
        steps(2);

        // ---------------- bounce on BTN[1] ----------------
        for (int j = 0; j < 6; j++) begin
            BTN[1] = pat[j];
            step();
            chk("bounce_no_press", 32'(btn_press), 32'h0);
        end
        steps(4);
        chk("bounce_press_early", 32'(btn_press), 32'h0);
        step();
        chk("bounce_press", 32'(btn_press), 32'h02);
        step();
        chk("bounce_press_once", 32'(btn_press), 32'h0);
        for (int j = 0; j < 10; j++) begin
            step();
            chk("bounce_no_release", 32'(btn_release), 32'h0);
        end
        chk("bounce_level", 32'(btn_level), 32'h02);
        BTN[1] = 1'b0;
        steps(8);

        // ---------------- hold tracker on SW[0] ----------------
        SW[0] = 1'b1;
        steps(5);
        chk("hold_sw_early", 32'(sw_level), 32'h0);
        step();
        chk("hold_sw_level", 32'(sw_level), 32'h0001);
        chk("hold_sw_rise", 32'(sw_rise), 32'h0001);
        for (int j = 0; j < 3; j++) begin
            steps(4);
            tick = 1'b1;
            step();
            tick = 1'b0;
            chk("hold_not_yet", 32'(paddle_hold_r), 32'h0);
        end
        step();
        chk("hold_assert", 32'(paddle_hold_r), 32'h1);
        for (int j = 0; j < 2; j++) begin
            steps(3);
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
            chk("hold_saturate", 32'(paddle_hold_r), 32'h1);
        end
        SW[0] = 1'b0;
        steps(5);
        chk("hold_drop_early", 32'(paddle_hold_r), 32'h1);
        step();
        chk("hold_drop_level", 32'(sw_level), 32'h0);
        chk("hold_drop_same_cycle", 32'(paddle_hold_r), 32'h1);
        step();
        chk("hold_deassert", 32'(paddle_hold_r), 32'h0);
        steps(2);

        // ---------------- reset mid-debounce ----------------
        BTN[4] = 1'b1;
        steps(2);
        chk("midrst_no_press", 32'(btn_press), 32'h0);
        chk("midrst_no_level", 32'(btn_level), 32'h0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        steps(5);
        chk("midrst_press_early", 32'(btn_press), 32'h0);
        step();
        chk("midrst_press", 32'(btn_press), 32'h10);
        chk("midrst_level", 32'(btn_level), 32'h10);
        BTN[4] = 1'b0;
        steps(8);

        // ---------------- simultaneous SW[15], SW[0], BTN[3] ----------------
        SW[15] = 1'b1;
        SW[0]  = 1'b1;
        BTN[3] = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            tick = (s % 2 == 0);
            step();
            if (s == 6) begin
                chk("sim_sw_rise", 32'(sw_rise), 32'h8001);
                chk("sim_btn_press", 32'(btn_press), 32'h08);
            end
            if (s == 10) chk("sim_hold_not_yet", 32'({paddle_hold_l, paddle_hold_r}), 32'h0);
            if (s >= 11) chk("sim_hold_both", 32'({paddle_hold_l, paddle_hold_r}), 32'h3);
        end
        tick = 1'b0;

        // asynchronous clear without a clock edge
        resetn = 1'b0;
        #2;
        chk("async_rst_holds", 32'({paddle_hold_l, paddle_hold_r}), 32'h0);
        chk("async_rst_sw_level", 32'(sw_level), 32'h0);
        chk("async_rst_btn_level", 32'(btn_level), 32'h0);
        step();
        resetn = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_conditioner.md
# input_conditioner

Front-end for all player inputs on the ping-pong board. It is the input-side counterpart of the LED and 7-segment output path. Every raw `BTN` and `SW` line is synchronised and debounced, and the block emits clean levels and one-cycle press/release strobes. It also tracks how long each paddle switch has been held, measured in game steps. The game core consumes only these outputs and no longer samples `BTN`/`SW` directly.

## Interface
Parameters:
- `DEB_CYCLES`, default 1000000: consecutive `clk` cycles an input must differ from its debounced level before the level flips (10 ms at 100 MHz). Must be ≥1.
- `HOLD_TICKS`, default 21: number of `tick` strobes a paddle switch must stay on before `paddle_hold_*` asserts. Must be ≥1.

Ports:
- `clk`, in, 1: system clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `BTN`, in, 5: raw push buttons, asynchronous to `clk`.
- `SW`, in, 16: raw slide switches, asynchronous to `clk`.
- `tick`, in, 1: one-cycle game-step strobe (the ball-advance enable).
- `btn_level`, out, 5: debounced button levels.
- `btn_press`, out, 5: one-cycle strobe on a debounced 0→1 transition.
- `btn_release`, out, 5: one-cycle strobe on a debounced 1→0 transition.
- `sw_level`, out, 16: debounced switch levels.
- `sw_rise`, out, 16: one-cycle strobe on a debounced 0→1 transition.
- `paddle_hold_r`, out, 1: `SW[0]` held on for ≥`HOLD_TICKS` ticks.
- `paddle_hold_l`, out, 1: `SW[15]` held on for ≥`HOLD_TICKS` ticks.

## Operation
- Each of the 21 inputs gets a 2-flop synchroniser (reset 0), then an independent debouncer. Channels share no state.
- Debouncer per channel: counter `dc` (width ≥ clog2(`DEB_CYCLES`+1)) and registered `level`.
  - When the synchronised value equals `level`: `dc` ← 0.
  - When it differs and `dc` == `DEB_CYCLES`−1: `level` flips and `dc` ← 0.
  - When it differs otherwise: `dc` ← `dc`+1.
  - Any glitch shorter than `DEB_CYCLES` cycles restarts the count and produces no level change.
- Strobes are registered. `btn_press`/`sw_rise`/`btn_release` are high exactly in the first cycle the new `level` is visible, and low the next cycle.
- Hold trackers are one each for `SW[0]` (right) and `SW[15]` (left). Each has a counter `hc`, 0..`HOLD_TICKS`.
  - `sw_level` bit = 0: `hc` ← 0 in that same cycle, regardless of `tick`.
  - `sw_level` bit = 1 and `tick`: `hc` ← min(`hc`+1, `HOLD_TICKS`). The counter saturates and never wraps.
  - `paddle_hold_*` = registered (`hc` == `HOLD_TICKS`).
- A `tick` coincident with the switch's debounced rising edge counts: the counter goes 0→1 on that edge.
- Reset: every synchroniser, `dc`, `level`, `hc` and every output clears to 0 immediately on `resetn` low, asynchronously. Reset asserted mid-debounce discards the partial count.
- After reset release, an input already held high produces a level rise and a press/rise strobe after the normal latency.

## Timing
- Raw edge to debounced `level`/strobe: `DEB_CYCLES`+2 `clk` edges for a stable input. There is ±1 cycle of synchroniser uncertainty for edges near the clock edge.
- Hold assertion: `paddle_hold_*` rises one `clk` after the edge on which `hc` reaches `HOLD_TICKS`.
- Hold deassertion: `paddle_hold_*` falls one `clk` after the `sw_level` bit falls.
- Pulse width: all strobes are exactly 1 cycle.
- Minimum debounced spacing: back-to-back strobes on one channel are ≥`DEB_CYCLES` cycles apart.
- All outputs come from flops; there are no combinational paths from input to output.

## Test plan
The bench uses `DEB_CYCLES`=4 and `HOLD_TICKS`=3.
- Reset: assert `resetn`=0 with all inputs at 1, release at cycle 10. All outputs stay 0 until cycle 16, then `btn_level`=5'h1F, `sw_level`=16'hFFFF and every `btn_press`/`sw_rise` bit pulses once at the same cycle.
- Clean press: `BTN[2]` 0→1, held for 20 cycles, then 1→0.
  - `btn_level[2]` rises exactly 6 edges after the raw edge, with `btn_press[2]` high for 1 cycle.
  - On release, `btn_release[2]` pulses 6 edges after the falling edge.
- Bounce: `BTN[1]` pattern 1,0,1,1,0,1 (one cycle each), then held at 1.
  - Exactly one `btn_press[1]`, 6 edges after the last 0→1.
  - No `btn_release[1]`.
- Hold: `SW[0]` held at 1, `tick` every 5 cycles.
  - `paddle_hold_r` asserts 1 cycle after the 3rd tick following the `sw_level[0]` rise, and stays asserted through further ticks (saturation).
  - Drop `SW[0]`: it deasserts 1 cycle after `sw_level[0]` falls.
- Reset mid-operation: start `BTN[4]` at 1, pulse `resetn` low after 2 stable cycles.
  - No strobe fires before reset.
  - After release, the press appears 6 edges later, not earlier.
- Simultaneity: `SW[15]`, `SW[0]` and `BTN[3]` rise together, with `tick` every 2 cycles.
  - `sw_rise[15]`, `sw_rise[0]` and `btn_press[3]` fire in the same cycle.
  - `paddle_hold_l` and `paddle_hold_r` assert in the same cycle.
